grid_renderer: RTL and testbench

GRID_RENDERER -- requirements
Module: grid_renderer

---
 rtl/grid_renderer_pkg.sv | 25 ++
 rtl/grid_renderer_if.sv | 40 ++++
 rtl/grid_cell_ram.sv | 46 ++++
 rtl/grid_renderer.sv | 186 ++++++++++++++++++
 tb/tb_grid_renderer.sv | 282 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/grid_renderer_pkg.sv
// Shared types and constants for the grid renderer.
//   color_t      : 3-bit {r,g,b} palette, CL0..CL7
//   BLACK/WHITE/RED : named palette entries
//   rend_state_t : controller FSM state
//   COORD_W, ROW_W, COL_W : widths of the pixel and cell address ports
package grid_renderer_pkg;

    typedef enum logic [2:0] {
        CL0, CL1, CL2, CL3, CL4, CL5, CL6, CL7
    } color_t;

    localparam color_t BLACK = CL0;
    localparam color_t WHITE = CL7;
    localparam color_t RED   = CL4;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } rend_state_t;

    localparam int COORD_W = 10;
    localparam int ROW_W   = 5;
    localparam int COL_W   = 4;

endpackage

// File: rtl/grid_renderer_if.sv
// Bus bundle between a VGA/host side (master) and the grid renderer (slave).
//   pixel   : pix_en, x_in, y_in -> color_out
//   write   : wr_valid/wr_ready handshake with wr_row, wr_col, wr_color
//   control : clear_req -> busy
//   query   : rd_row, rd_col -> rd_color (one cycle later)
interface grid_renderer_if
    import grid_renderer_pkg::*;
#(
    parameter int CW = 3
);
    logic               pix_en;
    logic [COORD_W-1:0] x_in;
    logic [COORD_W-1:0] y_in;
    logic [CW-1:0]      color_out;

    logic               wr_valid;
    logic               wr_ready;
    logic [ROW_W-1:0]   wr_row;
    logic [COL_W-1:0]   wr_col;
    logic [CW-1:0]      wr_color;

    logic               clear_req;
    logic               busy;

    logic [ROW_W-1:0]   rd_row;
    logic [COL_W-1:0]   rd_col;
    logic [CW-1:0]      rd_color;

    modport master (
        output pix_en, x_in, y_in, wr_valid, wr_row, wr_col, wr_color,
               clear_req, rd_row, rd_col,
        input  color_out, wr_ready, busy, rd_color
    );

    modport slave (
        input  pix_en, x_in, y_in, wr_valid, wr_row, wr_col, wr_color,
               clear_req, rd_row, rd_col,
        output color_out, wr_ready, busy, rd_color
    );
endinterface

// File: rtl/grid_cell_ram.sv
// Cell storage for the grid renderer: DEPTH cells of CW bits, row-major.
//   clk, rst_n        : clock, async active-low reset (clears every cell)
//   we/waddr/wdata    : single write port
//   re_a/raddr_a/rdata_a : pixel read port, registered, holds when re_a low
//   raddr_b/rdata_b   : query read port, registered every cycle
// Addresses >= DEPTH are a "no cell" sentinel: writes drop, reads give 0.
module grid_cell_ram #(
    parameter int DEPTH = 200,
    parameter int CW    = 3,
    parameter int AW    = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [CW-1:0] wdata,
    input  logic          re_a,
    input  logic [AW-1:0] raddr_a,
    output logic [CW-1:0] rdata_a,
    input  logic [AW-1:0] raddr_b,
    output logic [CW-1:0] rdata_b
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LIMIT = AW'(DEPTH);

    logic [CW-1:0] mem [DEPTH];

    // Reads see the contents from before this edge's write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (we && (waddr < LIMIT)) begin
                mem[IW'(waddr)] <= wdata;
            end
            if (re_a) begin
                rdata_a <= (raddr_a < LIMIT) ? mem[IW'(raddr_a)] : '0;
            end
            rdata_b <= (raddr_b < LIMIT) ? mem[IW'(raddr_b)] : '0;
        end
    end
endmodule

// File: rtl/grid_renderer.sv
// Playfield renderer: overlays a COLS x ROWS cell grid with 1-px grid lines
// onto a raster stream, with a handshaked cell-write port, a clear sweep and
// a one-cycle query port.
//   clk, rst_n : clock, async active-low reset
//   bus        : grid_renderer_if.slave (pixel, write, clear, query groups)
// Pixel pipeline: stage 1 steps the cell counters and reads the cell RAM,
// stage 2 picks background / line / cell colour into color_out.
//
// state    | meaning
// ---------+------------------------------------------------------------
// ST_IDLE  | accepting cell writes (wr_ready=1, busy=0)
// ST_CLEAR | zeroing one cell per cycle, row-major (wr_ready=0, busy=1)
module grid_renderer
    import grid_renderer_pkg::*;
#(
    parameter int COLS  = 10,
    parameter int ROWS  = 20,
    parameter int BLOCK = 15,
    parameter int X0    = 245,
    parameter int Y0    = 90,
    parameter int CW    = 3,
    parameter logic [CW-1:0] LINE_COLOR = CW'(WHITE),
    parameter logic [CW-1:0] BG_COLOR   = CW'(BLACK)
) (
    input logic           clk,
    input logic           rst_n,
    grid_renderer_if.slave bus
);
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH + 1);
    localparam int CNT_W = COORD_W;

    rend_state_t    state;
    logic [AW-1:0]  clr_addr;
    logic           busy_q;
    logic           wr_ready_q;

    logic [CNT_W-1:0] px, col, py, row;
    logic [CNT_W-1:0] px_nxt, col_nxt, py_nxt, row_nxt;
    logic             in_grid, line_nxt;
    logic             in_grid_q, line_q;
    logic [CW-1:0]    color_q;

    logic [AW-1:0]  pix_addr, wr_addr, rd_addr;
    logic           ram_we;
    logic [AW-1:0]  ram_waddr;
    logic [CW-1:0]  ram_wdata;
    logic [CW-1:0]  cell_pix, rd_data;

    // Counters follow the pixel presented this cycle; px/py are the offsets
    // inside the current cell, col/row the cell indices.
    always_comb begin
        px_nxt  = px;
        col_nxt = col;
        py_nxt  = py;
        row_nxt = row;
        if (int'(bus.x_in) == X0) begin
            px_nxt  = '0;
            col_nxt = '0;
            if (int'(bus.y_in) == Y0) begin
                py_nxt  = '0;
                row_nxt = '0;
            end else if (int'(bus.y_in) > Y0) begin
                if (int'(py) == BLOCK - 1) begin
                    py_nxt  = '0;
                    row_nxt = row + CNT_W'(1);
                end else begin
                    py_nxt = py + CNT_W'(1);
                end
            end
        end else if (int'(px) == BLOCK - 1) begin
            px_nxt  = '0;
            col_nxt = col + CNT_W'(1);
        end else begin
            px_nxt = px + CNT_W'(1);
        end
    end

    always_comb begin
        in_grid = (int'(bus.x_in) >= X0) && (int'(bus.x_in) < X0 + COLS * BLOCK) &&
                  (int'(bus.y_in) >= Y0) && (int'(bus.y_in) < Y0 + ROWS * BLOCK);
        line_nxt = (px_nxt == '0) || (py_nxt == '0) ||
                   (int'(bus.x_in) == X0 + COLS * BLOCK - 1) ||
                   (int'(bus.y_in) == Y0 + ROWS * BLOCK - 1);
    end

    // Counters run past the grid outside it; those positions map to the
    // sentinel address so the RAM returns 0 instead of aliasing a cell.
    always_comb begin
        pix_addr = AW'(DEPTH);
        if ((int'(row_nxt) < ROWS) && (int'(col_nxt) < COLS)) begin
            pix_addr = AW'(row_nxt) * AW'(COLS) + AW'(col_nxt);
        end
        wr_addr = AW'(DEPTH);
        if ((int'(bus.wr_row) < ROWS) && (int'(bus.wr_col) < COLS)) begin
            wr_addr = AW'(bus.wr_row) * AW'(COLS) + AW'(bus.wr_col);
        end
        rd_addr = AW'(DEPTH);
        if ((int'(bus.rd_row) < ROWS) && (int'(bus.rd_col) < COLS)) begin
            rd_addr = AW'(bus.rd_row) * AW'(COLS) + AW'(bus.rd_col);
        end
    end

    // The sweep owns the write port while clearing; a host write and the
    // clear request in the same cycle therefore land first, then get erased.
    always_comb begin
        ram_we    = (state == ST_CLEAR) || (bus.wr_valid && wr_ready_q);
        ram_waddr = (state == ST_CLEAR) ? clr_addr : wr_addr;
        ram_wdata = (state == ST_CLEAR) ? '0 : bus.wr_color;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            clr_addr   <= '0;
            busy_q     <= 1'b0;
            wr_ready_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    wr_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                    if (bus.clear_req) begin
                        state      <= ST_CLEAR;
                        clr_addr   <= '0;
                        busy_q     <= 1'b1;
                        wr_ready_q <= 1'b0;
                    end
                end
                ST_CLEAR: begin
                    if (clr_addr == AW'(DEPTH - 1)) begin
                        state      <= ST_IDLE;
                        clr_addr   <= '0;
                        busy_q     <= 1'b0;
                        wr_ready_q <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + AW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            px        <= '0;
            col       <= '0;
            py        <= '0;
            row       <= '0;
            in_grid_q <= 1'b0;
            line_q    <= 1'b0;
            color_q   <= BG_COLOR;
        end else if (bus.pix_en) begin
            px        <= px_nxt;
            col       <= col_nxt;
            py        <= py_nxt;
            row       <= row_nxt;
            in_grid_q <= in_grid;
            line_q    <= line_nxt;
            color_q   <= !in_grid_q ? BG_COLOR : (line_q ? LINE_COLOR : cell_pix);
        end
    end

    grid_cell_ram #(
        .DEPTH (DEPTH),
        .CW    (CW),
        .AW    (AW)
    ) u_cells (
        .clk     (clk),
        .rst_n   (rst_n),
        .we      (ram_we),
        .waddr   (ram_waddr),
        .wdata   (ram_wdata),
        .re_a    (bus.pix_en),
        .raddr_a (pix_addr),
        .rdata_a (cell_pix),
        .raddr_b (rd_addr),
        .rdata_b (rd_data)
    );

    assign bus.color_out = color_q;
    assign bus.wr_ready  = wr_ready_q;
    assign bus.busy      = busy_q;
    assign bus.rd_color  = rd_data;
endmodule

// File: tb/tb_grid_renderer.sv
module tb_grid_renderer;
    import grid_renderer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    grid_renderer_if b1 ();
    grid_renderer_if b2 ();

    grid_renderer u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b1)
    );

    grid_renderer #(.COLS(12), .ROWS(22), .BLOCK(10)) u_dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (b2)
    );

    int checks = 0;
    int errors = 0;
    logic [2:0] cells [20][10];

    typedef struct {
        int         row;
        int         col;
        logic [2:0] color;
        logic [2:0] exp_rd;
    } wr_vec_t;

    typedef struct {
        int         x;
        int         y;
        int         dut;
        logic [2:0] exp;
    } spot_t;

    wr_vec_t wv [7];
    spot_t   spots [16];
    bit      spot_hit [16];

    logic [2:0] e1_s1, e1_s2, e2_s1, e2_s2;
    int sx1, sy1, sx2, sy2;
    int ferr1, ferr2;
    string fbad1, fbad2;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model_px(int x, int y, int cols, int rows, int blk, bit use_cells);
        int gx = x - 245;
        int gy = y - 90;
        if (gx < 0 || gy < 0 || gx >= cols * blk || gy >= rows * blk) return 3'd0;
        if ((gx % blk) == 0 || (gy % blk) == 0 || gx == cols * blk - 1 || gy == rows * blk - 1)
            return 3'd7;
        if (use_cells) return cells[gy / blk][gx / blk];
        return 3'd0;
    endfunction

    task automatic cmp_frame();
        if (b1.color_out !== e1_s2) begin
            if (ferr1 == 0) fbad1 = $sformatf("(%0d,%0d) got %0h exp %0h", sx2, sy2, b1.color_out, e1_s2);
            ferr1++;
        end
        if (b2.color_out !== e2_s2) begin
            if (ferr2 == 0) fbad2 = $sformatf("(%0d,%0d) got %0h exp %0h", sx2, sy2, b2.color_out, e2_s2);
            ferr2++;
        end
    endtask

    task automatic pix_step(int x, int y);
        b1.pix_en = 1'b1; b1.x_in = 10'(x); b1.y_in = 10'(y);
        b2.pix_en = 1'b1; b2.x_in = 10'(x); b2.y_in = 10'(y);
        tick();
        b1.pix_en = 1'b0;
        b2.pix_en = 1'b0;
        e1_s2 = e1_s1; e1_s1 = model_px(x, y, 10, 20, 15, 1'b1);
        e2_s2 = e2_s1; e2_s1 = model_px(x, y, 12, 22, 10, 1'b0);
        sx2 = sx1; sy2 = sy1; sx1 = x; sy1 = y;
        cmp_frame();
        for (int i = 0; i < 16; i++) begin
            if (!spot_hit[i] && spots[i].x == sx2 && spots[i].y == sy2) begin
                spot_hit[i] = 1'b1;
                chk($sformatf("spot_d%0d_%0d_%0d", spots[i].dut, sx2, sy2),
                    (spots[i].dut == 1) ? b1.color_out : b2.color_out, spots[i].exp);
            end
        end
    endtask

    task automatic write_cell(string tag, int r, int c, logic [2:0] color);
        b1.wr_valid = 1'b1; b1.wr_row = 5'(r); b1.wr_col = 4'(c); b1.wr_color = color;
        chk({tag, "_wr_ready"}, b1.wr_ready, 1);
        tick();
        b1.wr_valid = 1'b0;
        if (r < 20 && c < 10) cells[r][c] = color;
    endtask

    task automatic read_cell(string tag, int r, int c, logic [2:0] exp);
        b1.rd_row = 5'(r); b1.rd_col = 4'(c);
        tick();
        chk($sformatf("%s_rd_%0d_%0d", tag, r, c), b1.rd_color, exp);
    endtask

    task automatic readback(string tag);
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                read_cell(tag, r, c, cells[r][c]);
    endtask

    task automatic clear_model();
        for (int r = 0; r < 20; r++)
            for (int c = 0; c < 10; c++)
                cells[r][c] = 3'd0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int cnt;
        int rdy_bad;

        b1.pix_en = 0; b1.x_in = 0; b1.y_in = 0; b1.wr_valid = 0; b1.wr_row = 0;
        b1.wr_col = 0; b1.wr_color = 0; b1.clear_req = 0; b1.rd_row = 0; b1.rd_col = 0;
        b2.pix_en = 0; b2.x_in = 0; b2.y_in = 0; b2.wr_valid = 0; b2.wr_row = 0;
        b2.wr_col = 0; b2.wr_color = 0; b2.clear_req = 0; b2.rd_row = 0; b2.rd_col = 0;
        clear_model();

        wv[0] = '{row: 14, col: 4,  color: 3'd4, exp_rd: 3'd4};
        wv[1] = '{row: 19, col: 9,  color: 3'd1, exp_rd: 3'd1};
        wv[2] = '{row: 25, col: 3,  color: 3'd4, exp_rd: 3'd0};
        wv[3] = '{row: 5,  col: 10, color: 3'd6, exp_rd: 3'd0};
        wv[4] = '{row: 5,  col: 9,  color: 3'd3, exp_rd: 3'd3};
        wv[5] = '{row: 7,  col: 2,  color: 3'd5, exp_rd: 3'd5};
        wv[6] = '{row: 0,  col: 1,  color: 3'd2, exp_rd: 3'd2};

        spots[0]  = '{x: 100, y: 100, dut: 1, exp: 3'd0};
        spots[1]  = '{x: 246, y: 91,  dut: 1, exp: 3'd0};
        spots[2]  = '{x: 245, y: 100, dut: 1, exp: 3'd7};
        spots[3]  = '{x: 307, y: 302, dut: 1, exp: 3'd4};
        spots[4]  = '{x: 319, y: 314, dut: 1, exp: 3'd4};
        spots[5]  = '{x: 305, y: 300, dut: 1, exp: 3'd7};
        spots[6]  = '{x: 394, y: 200, dut: 1, exp: 3'd7};
        spots[7]  = '{x: 395, y: 200, dut: 1, exp: 3'd0};
        spots[8]  = '{x: 300, y: 389, dut: 1, exp: 3'd7};
        spots[9]  = '{x: 300, y: 390, dut: 1, exp: 3'd0};
        spots[10] = '{x: 364, y: 150, dut: 2, exp: 3'd7};
        spots[11] = '{x: 365, y: 150, dut: 2, exp: 3'd0};
        spots[12] = '{x: 300, y: 309, dut: 2, exp: 3'd7};
        spots[13] = '{x: 300, y: 310, dut: 2, exp: 3'd0};
        spots[14] = '{x: 246, y: 91,  dut: 2, exp: 3'd0};
        spots[15] = '{x: 255, y: 91,  dut: 2, exp: 3'd7};
        for (int i = 0; i < 16; i++) spot_hit[i] = 1'b0;

        // reset state
        #2;
        tick();
        tick();
        chk("rst_color1", b1.color_out, 0);
        chk("rst_rd1", b1.rd_color, 0);
        chk("rst_busy1", b1.busy, 0);
        chk("rst_wr_ready1", b1.wr_ready, 0);
        chk("rst_color2", b2.color_out, 0);
        chk("rst_wr_ready2", b2.wr_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("wr_ready_rise1", b1.wr_ready, 1);
        chk("wr_ready_rise2", b2.wr_ready, 1);
        chk("busy_after_rst", b1.busy, 0);

        // table-driven writes with query readback
        for (int i = 0; i < 7; i++) begin
            write_cell($sformatf("vec%0d", i), wv[i].row, wv[i].col, wv[i].color);
            read_cell($sformatf("vec%0d", i), wv[i].row, wv[i].col, wv[i].exp_rd);
        end
        readback("fill");

        // frame window scan on both instances, random pix_en gaps
        e1_s1 = 3'd0; e1_s2 = 3'd0; e2_s1 = 3'd0; e2_s2 = 3'd0;
        sx1 = -1; sy1 = -1; sx2 = -1; sy2 = -1;
        ferr1 = 0; ferr2 = 0; fbad1 = ""; fbad2 = "";
        pix_step(100, 100);
        for (int y = 88; y <= 391; y++) begin
            for (int x = 243; x <= 396; x++) begin
                while ($urandom_range(0, 7) == 0) begin
                    tick();
                    cmp_frame();
                end
                pix_step(x, y);
            end
        end
        pix_step(0, 392);
        chk({"frame_default ", fbad1}, ferr1, 0);
        chk({"frame_param ", fbad2}, ferr2, 0);
        cnt = 0;
        for (int i = 0; i < 16; i++) if (spot_hit[i]) cnt++;
        chk("spots_reached", cnt, 16);

        // clear sweep with wr_valid held and a second clear_req mid-sweep
        b1.clear_req = 1'b1;
        tick();
        b1.clear_req = 1'b0;
        b1.wr_valid = 1'b1; b1.wr_row = 5'd3; b1.wr_col = 4'd3; b1.wr_color = 3'd7;
        chk("clear_busy_start", b1.busy, 1);
        cnt = 0;
        rdy_bad = 0;
        while (b1.busy === 1'b1 && cnt < 400) begin
            cnt++;
            if (b1.wr_ready !== 1'b0) rdy_bad++;
            b1.clear_req = (cnt == 100);
            tick();
        end
        b1.wr_valid = 1'b0;
        b1.clear_req = 1'b0;
        chk("clear_busy_len", cnt, 200);
        chk("clear_ready_low", rdy_bad, 0);
        chk("clear_ready_back", b1.wr_ready, 1);
        clear_model();
        readback("clear");

        // write and clear_req in the same cycle
        b1.rd_row = 5'd0; b1.rd_col = 4'd0;
        b1.wr_valid = 1'b1; b1.wr_row = 5'd0; b1.wr_col = 4'd0; b1.wr_color = 3'd4;
        b1.clear_req = 1'b1;
        tick();
        b1.wr_valid = 1'b0;
        b1.clear_req = 1'b0;
        chk("wc_busy", b1.busy, 1);
        tick();
        chk("wc_write_landed", b1.rd_color, 4);
        cnt = 0;
        while (b1.busy === 1'b1 && cnt < 400) begin
            cnt++;
            tick();
        end
        chk("wc_sweep_done", b1.busy, 0);
        read_cell("wc_after", 0, 0, 3'd0);

        // reset in the middle of a sweep
        write_cell("pre_rst", 15, 5, 3'd3);
        read_cell("pre_rst", 15, 5, 3'd3);
        b1.clear_req = 1'b1;
        tick();
        b1.clear_req = 1'b0;
        repeat (50) tick();
        chk("mid_sweep_busy", b1.busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_mid_busy", b1.busy, 0);
        chk("rst_mid_wr_ready", b1.wr_ready, 0);
        chk("rst_mid_rd", b1.rd_color, 0);
        chk("rst_mid_color", b1.color_out, 0);
        clear_model();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("rst_mid_ready_rise", b1.wr_ready, 1);
        chk("rst_mid_idle", b1.busy, 0);
        readback("reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
